// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared types and constants for the control unit.
//   state_t  : FSM state encoding (RST, T0..T7, PAUSE, HALT)
//   OP_*     : 5-bit opcode constants; opcode sits in the top OP_W bits of IR
//   strobe_t : one bit per datapath control strobe
//   is_legal / last_step / step_next : opcode and sequencing helpers
package cpu_ctrl_pkg;

  localparam int OP_W = 5;  // opcode = IR[IR_W-1 -: OP_W]

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, write;
    logic ir_in, y_in, zlow_in, zlow_out, c_out, con_in;
    logic gra, grb, grc, r_in, r_out, ba_out, link_sel;
  } strobe_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_BR, OP_JR, OP_JAL, OP_NOP, OP_HALT: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  // Final execute step for opcodes that go past T2.
  function automatic state_t last_step(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: last_step = S_T5;
      OP_LD, OP_ST:                                   last_step = S_T7;
      OP_BR:                                          last_step = S_T6;
      OP_JAL:                                         last_step = S_T4;
      default:                                        last_step = S_T3;  // jr
    endcase
  endfunction

  function automatic state_t step_next(input state_t s);
    case (s)
      S_T3:    step_next = S_T4;
      S_T4:    step_next = S_T5;
      S_T5:    step_next = S_T6;
      S_T6:    step_next = S_T7;
      default: step_next = S_T0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational Moore decode of (state, opcode) to strobes.
//   state   : current FSM state
//   op      : opcode latched at T2 (used from T3 on)
//   con     : branch condition, gates the br T6 step only
//   strobes : datapath control strobes
//   run     : high in T0..T7
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t            state,
  input  logic [OP_W-1:0]   op,
  input  logic              con,
  output strobe_t           strobes,
  output logic              run
);

  logic alu_op;
  assign alu_op = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

  always_comb begin
    strobes = '0;
    run     = 1'b0;
    case (state)
      S_T0: begin
        run = 1'b1;
        strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1; strobes.zlow_in = 1'b1;
      end
      S_T1: begin
        run = 1'b1;
        strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1;
        strobes.read = 1'b1;     strobes.mdr_in = 1'b1;
      end
      S_T2: begin
        run = 1'b1;
        strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (alu_op || op == OP_ADDI) begin
          strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
        end else if (op == OP_LDI || op == OP_LD || op == OP_ST) begin
          strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
        end else if (op == OP_BR) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1;
        end else if (op == OP_JAL) begin
          strobes.pc_out = 1'b1; strobes.link_sel = 1'b1; strobes.r_in = 1'b1;
        end else if (op == OP_JR) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (alu_op) begin
          strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.zlow_in = 1'b1;
        end else if (op == OP_ADDI || op == OP_LDI || op == OP_LD || op == OP_ST) begin
          strobes.c_out = 1'b1; strobes.zlow_in = 1'b1;
        end else if (op == OP_BR) begin
          strobes.pc_out = 1'b1; strobes.y_in = 1'b1;
        end else if (op == OP_JAL) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1;
        end
      end
      S_T5: begin
        run = 1'b1;
        if (alu_op || op == OP_ADDI || op == OP_LDI) begin
          strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (op == OP_LD || op == OP_ST) begin
          strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
        end else if (op == OP_BR) begin
          strobes.c_out = 1'b1; strobes.zlow_in = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (op == OP_LD) begin
          strobes.read = 1'b1; strobes.mdr_in = 1'b1;
        end else if (op == OP_ST) begin
          strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
        end else if (op == OP_BR && con) begin
          strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (op == OP_LD) begin
          strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
        end else if (op == OP_ST) begin
          strobes.write = 1'b1;
        end
      end
      default: ;  // RST, PAUSE, HALT: all strobes low
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- fetch/execute sequencer for the 3-bus datapath.
//   Clock, Clear (async active-low) ; IR (instruction), CON (branch flag),
//   Stop (pause request, honoured at instruction boundaries only)
//   Outputs: datapath strobes, Run (fetching/executing), Illegal (sticky).
// Build option: ILLEGAL_OP_TRAP_EN -- undefined opcodes trap to HALT and
// set Illegal; otherwise they run as nop and Illegal stays 0.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [IR_W-1:0] IR,
  input  logic            CON,
  input  logic            Stop,
  output logic PCout, PCin, IncPC,
  output logic MARin, MDRin, MDRout, Read, Write,
  output logic IRin, Yin, ZLowIn, ZLowout, Cout, CONin,
  output logic Gra, Grb, Grc, Rin, Rout, BAout, LinkSel,
  output logic Run,
  output logic Illegal
);

  state_t          state;
  logic [OP_W-1:0] op_q;     // opcode captured as IR loads at end of T2
  logic [OP_W-1:0] opcode;
  state_t          done_next;
  strobe_t         s;

  assign opcode    = IR[IR_W-1 -: OP_W];
  assign done_next = Stop ? S_PAUSE : S_T0;

  // Operand fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^IR[IR_W-OP_W-1:0];

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      case (state)
        S_RST: state <= S_T0;
        S_T0:  state <= S_T1;
        S_T1:  state <= S_T2;
        S_T2: begin
          op_q <= opcode;
          if (opcode == OP_HALT)    state <= S_HALT;
          else if (!is_legal(opcode))
`ifdef ILLEGAL_OP_TRAP_EN
                                    state <= S_HALT;
`else
                                    state <= done_next;
`endif
          else if (opcode == OP_NOP) state <= done_next;
          else                       state <= S_T3;
        end
        S_T3, S_T4, S_T5, S_T6, S_T7:
          state <= (state == last_step(op_q)) ? done_next : step_next(state);
        S_PAUSE: if (!Stop) state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear)                                 illegal_q <= 1'b0;
    else if (state == S_T2 && !is_legal(opcode)) illegal_q <= 1'b1;
  end
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  ctrl_decode u_decode (
    .state   (state),
    .op      (op_q),
    .con     (CON),
    .strobes (s),
    .run     (Run)
  );

  assign PCout   = s.pc_out;   assign PCin    = s.pc_in;    assign IncPC  = s.inc_pc;
  assign MARin   = s.mar_in;   assign MDRin   = s.mdr_in;   assign MDRout = s.mdr_out;
  assign Read    = s.read;     assign Write   = s.write;    assign IRin   = s.ir_in;
  assign Yin     = s.y_in;     assign ZLowIn  = s.zlow_in;  assign ZLowout = s.zlow_out;
  assign Cout    = s.c_out;    assign CONin   = s.con_in;   assign Gra    = s.gra;
  assign Grb     = s.grb;      assign Grc     = s.grc;      assign Rin    = s.r_in;
  assign Rout    = s.r_out;    assign BAout   = s.ba_out;   assign LinkSel = s.link_sel;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- table-driven check of control_unit strobe sequences,
// plus hand-written sequences for async clear, illegal opcode and halt.
// Honours ILLEGAL_OP_TRAP_EN for the illegal-opcode expectations.
module tb_control_unit;

  typedef logic [21:0] vec_t;
  localparam vec_t PCOUT = 22'd1 << 21, PCIN  = 22'd1 << 20, INCPC = 22'd1 << 19,
                   MARIN = 22'd1 << 18, MDRIN = 22'd1 << 17, MDROUT = 22'd1 << 16,
                   READ  = 22'd1 << 15, WRITE = 22'd1 << 14, IRIN  = 22'd1 << 13,
                   YIN   = 22'd1 << 12, ZLIN  = 22'd1 << 11, ZLOUT = 22'd1 << 10,
                   COUT  = 22'd1 << 9,  CONIN = 22'd1 << 8,  GRA   = 22'd1 << 7,
                   GRB   = 22'd1 << 6,  GRC   = 22'd1 << 5,  RIN   = 22'd1 << 4,
                   ROUT  = 22'd1 << 3,  BAOUT = 22'd1 << 2,  LINK  = 22'd1 << 1,
                   RUN   = 22'd1;
  localparam vec_t T0V = PCOUT | MARIN | INCPC | ZLIN | RUN;
  localparam vec_t T1V = ZLOUT | PCIN | READ | MDRIN | RUN;
  localparam vec_t T2V = MDROUT | IRIN | RUN;

  localparam logic [4:0] O_LD = 5'b00000, O_LDI = 5'b00001, O_ST = 5'b00010,
                         O_ADD = 5'b00011, O_SUB = 5'b00100, O_ADDI = 5'b01100,
                         O_BR = 5'b10010, O_JR = 5'b10011, O_JAL = 5'b10100,
                         O_NOP = 5'b11010, O_HALT = 5'b11011, O_BAD = 5'b11111;

  logic        Clock, Clear, CON, Stop;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
  logic IRin, Yin, ZLowIn, ZLowout, Cout, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, LinkSel, Run, Illegal;
  vec_t obs;

  control_unit #(.IR_W(32)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZLowout(ZLowout), .Cout(Cout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .LinkSel(LinkSel),
    .Run(Run), .Illegal(Illegal)
  );

  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
                ZLowIn, ZLowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, LinkSel, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       clr;
    logic [4:0] op;
    logic       con;
    logic       stop;
    vec_t       exp;
  } row_t;
  row_t rows[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input vec_t exp, input logic ill);
    total++;
    if (obs !== exp || Illegal !== ill) begin
      bad++;
      $display("FAIL %s: got strobes=%b illegal=%b, want strobes=%b illegal=%b",
               nm, obs, Illegal, exp, ill);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check the current state's outputs.
  task automatic step(input string nm, input logic clr, input logic [4:0] op,
                      input logic con, input logic stop, input vec_t exp, input logic ill);
    @(negedge Clock);
    Clear = clr;
    IR    = {op, 27'h0123456};
    CON   = con;
    Stop  = stop;
    #1;
    check(nm, exp, ill);
  endtask

  task automatic add_row(input logic clr, input logic [4:0] op, input logic con,
                         input logic stop, input vec_t exp);
    row_t r;
    r.clr = clr; r.op = op; r.con = con; r.stop = stop; r.exp = exp;
    rows.push_back(r);
  endtask

  // Stop during T0/T1 must be ignored; T2 always sees stop=0 here.
  task automatic fetch(input logic [4:0] op, input logic con, input logic stop);
    add_row(1'b1, op, con, stop, T0V);
    add_row(1'b1, op, con, stop, T1V);
    add_row(1'b1, op, con, 1'b0, T2V);
  endtask

  initial begin
    Clear = 1'b0; IR = '0; CON = 1'b0; Stop = 1'b0;

    add_row(1'b0, O_NOP, 1'b0, 1'b0, '0);          // held in reset
    add_row(1'b1, O_LDI, 1'b0, 1'b1, '0);          // released, still RST; Stop ignored
    fetch(O_LDI, 1'b0, 1'b1);
    add_row(1'b1, O_LDI, 1'b0, 1'b0, GRB | BAOUT | YIN | RUN);
    add_row(1'b1, O_LDI, 1'b0, 1'b0, COUT | ZLIN | RUN);
    add_row(1'b1, O_LDI, 1'b0, 1'b0, ZLOUT | GRA | RIN | RUN);
    fetch(O_JAL, 1'b0, 1'b0);
    add_row(1'b1, O_JAL, 1'b0, 1'b0, PCOUT | LINK | RIN | RUN);
    add_row(1'b1, O_JAL, 1'b0, 1'b0, GRA | ROUT | PCIN | RUN);
    for (int c = 0; c < 2; c++) begin
      fetch(O_BR, c[0], 1'b0);
      add_row(1'b1, O_BR, c[0], 1'b0, GRA | ROUT | CONIN | RUN);
      add_row(1'b1, O_BR, c[0], 1'b0, PCOUT | YIN | RUN);
      add_row(1'b1, O_BR, c[0], 1'b0, COUT | ZLIN | RUN);
      add_row(1'b1, O_BR, c[0], 1'b0, c[0] ? (ZLOUT | PCIN | RUN) : RUN);
    end
    fetch(O_ADD, 1'b0, 1'b0);
    add_row(1'b1, O_ADD, 1'b0, 1'b0, GRB | ROUT | YIN | RUN);
    add_row(1'b1, O_ADD, 1'b0, 1'b1, GRC | ROUT | ZLIN | RUN);  // Stop raised in T4
    add_row(1'b1, O_ADD, 1'b0, 1'b1, ZLOUT | GRA | RIN | RUN);
    add_row(1'b1, O_ADD, 1'b0, 1'b1, '0);                      // PAUSE
    add_row(1'b1, O_ADD, 1'b0, 1'b0, '0);                      // PAUSE, Stop drops
    fetch(O_SUB, 1'b0, 1'b0);
    add_row(1'b1, O_SUB, 1'b0, 1'b0, GRB | ROUT | YIN | RUN);
    add_row(1'b1, O_SUB, 1'b0, 1'b0, GRC | ROUT | ZLIN | RUN);
    add_row(1'b1, O_SUB, 1'b0, 1'b0, ZLOUT | GRA | RIN | RUN);
    fetch(O_ADDI, 1'b0, 1'b0);
    add_row(1'b1, O_ADDI, 1'b0, 1'b0, GRB | ROUT | YIN | RUN);
    add_row(1'b1, O_ADDI, 1'b0, 1'b0, COUT | ZLIN | RUN);
    add_row(1'b1, O_ADDI, 1'b0, 1'b0, ZLOUT | GRA | RIN | RUN);
    fetch(O_ST, 1'b0, 1'b0);
    add_row(1'b1, O_ST, 1'b0, 1'b0, GRB | BAOUT | YIN | RUN);
    add_row(1'b1, O_ST, 1'b0, 1'b0, COUT | ZLIN | RUN);
    add_row(1'b1, O_ST, 1'b0, 1'b0, ZLOUT | MARIN | RUN);
    add_row(1'b1, O_ST, 1'b0, 1'b0, GRA | ROUT | MDRIN | RUN);
    add_row(1'b1, O_ST, 1'b0, 1'b1, WRITE | RUN);              // Stop at last step
    add_row(1'b1, O_ST, 1'b0, 1'b0, '0);                       // PAUSE one cycle
    fetch(O_JR, 1'b0, 1'b0);
    add_row(1'b1, O_JR, 1'b0, 1'b0, GRA | ROUT | PCIN | RUN);
    fetch(O_NOP, 1'b0, 1'b0);                                  // T2 -> T0
    fetch(O_LD, 1'b0, 1'b0);
    add_row(1'b1, O_LD, 1'b0, 1'b0, GRB | BAOUT | YIN | RUN);
    add_row(1'b1, O_LD, 1'b0, 1'b0, COUT | ZLIN | RUN);
    add_row(1'b1, O_LD, 1'b0, 1'b0, ZLOUT | MARIN | RUN);
    add_row(1'b1, O_LD, 1'b0, 1'b0, READ | MDRIN | RUN);       // T6

    foreach (rows[i])
      step($sformatf("row%0d", i), rows[i].clr, rows[i].op, rows[i].con,
           rows[i].stop, rows[i].exp, 1'b0);

    // Clear pulsed mid-T6 of ld: outputs drop before any clock edge.
    #2 Clear = 1'b0;
    #1 check("clr_async", '0, 1'b0);
    step("clr_release", 1'b1, O_BAD, 1'b0, 1'b0, '0, 1'b0);
    step("clr_t0",      1'b1, O_BAD, 1'b0, 1'b0, T0V, 1'b0);

    // Undefined opcode 11111.
    step("bad_t1", 1'b1, O_BAD, 1'b0, 1'b0, T1V, 1'b0);
    step("bad_t2", 1'b1, O_BAD, 1'b0, 1'b0, T2V, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    step("bad_halt0", 1'b1, O_BAD, 1'b0, 1'b0, '0, 1'b1);
    step("bad_halt1", 1'b1, O_BAD, 1'b0, 1'b1, '0, 1'b1);
`else
    step("bad_t0",    1'b1, O_BAD, 1'b0, 1'b0, T0V, 1'b0);
    step("bad_t1b",   1'b1, O_BAD, 1'b0, 1'b0, T1V, 1'b0);
`endif

    // Reset, then halt opcode: HALT absorbs, Illegal stays 0.
    step("rst2",      1'b0, O_HALT, 1'b0, 1'b0, '0, 1'b0);
    step("rst2_rel",  1'b1, O_HALT, 1'b0, 1'b0, '0, 1'b0);
    step("halt_t0",   1'b1, O_HALT, 1'b0, 1'b0, T0V, 1'b0);
    step("halt_t1",   1'b1, O_HALT, 1'b0, 1'b0, T1V, 1'b0);
    step("halt_t2",   1'b1, O_HALT, 1'b0, 1'b0, T2V, 1'b0);
    step("halt_s0",   1'b1, O_HALT, 1'b0, 1'b1, '0, 1'b0);
    step("halt_s1",   1'b1, O_HALT, 1'b0, 1'b0, '0, 1'b0);
    step("halt_s2",   1'b1, O_LDI,  1'b1, 1'b0, '0, 1'b0);
    step("halt_clr",  1'b0, O_LDI,  1'b0, 1'b0, '0, 1'b0);
    step("halt_rel",  1'b1, O_LDI,  1'b0, 1'b1, '0, 1'b0);
    step("halt_out",  1'b1, O_LDI,  1'b0, 1'b0, T0V, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
